// File: rtl/cplx_mag2_if.sv
// Request/result bundle for the serial magnitude-squared unit.
// The master drives start/i_in/q_in and the slave returns busy/rdy/mag2.
// Widths follow W: W-bit signed samples in, 2W-bit unsigned result out.
interface cplx_mag2_if #(
  parameter int W = 16
);
  logic                start;
  logic signed [W-1:0] i_in;
  logic signed [W-1:0] q_in;
  logic                busy;
  logic                rdy;
  logic [2*W-1:0]      mag2;

  modport master (
    output start, i_in, q_in,
    input  busy, rdy, mag2
  );

  modport slave (
    input  start, i_in, q_in,
    output busy, rdy, mag2
  );
endinterface

// File: rtl/cplx_mag2.sv
// Serial |i|^2 + |q|^2 using one shift-add multiplier reused for both squares.
// Latency: 2W cycles from the start edge to rdy (W cycles per square).
// One operation in flight; start while busy is ignored, rdy holds until the next start.
module cplx_mag2 #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        reset,
  cplx_mag2_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SQ_I, SQ_Q, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   mplier_q;
  logic [W-1:0]   q_abs_q;
  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mag2_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           rdy_q;

  logic [W-1:0]   i_abs_d;
  logic [W-1:0]   q_abs_d;
  logic [2*W-1:0] acc_d;
  logic           last_d;

  // Magnitudes of the samples (-2^(W-1) maps to 2^(W-1) as unsigned) and one multiply step.
  always_comb begin
    i_abs_d = bus.i_in[W-1] ? ({W{1'b0}} - bus.i_in) : bus.i_in;
    q_abs_d = bus.q_in[W-1] ? ({W{1'b0}} - bus.q_in) : bus.q_in;
    acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_d  = (cnt_q == CW'(W - 1));
  end

  // Control FSM and datapath: capture, square |i|, square |q| onto the same sum, present result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mplier_q <= '0;
      q_abs_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mag2_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            mplier_q <= i_abs_d;
            mcand_q  <= {{W{1'b0}}, i_abs_d};
            q_abs_q  <= q_abs_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            rdy_q    <= 1'b0;
            state_q  <= SQ_I;
          end
        end
        SQ_I: begin
          acc_q <= acc_d;
          if (last_d) begin
            // Reload the multiplier pair with |q|; the accumulator carries i^2 forward.
            mplier_q <= q_abs_q;
            mcand_q  <= {{W{1'b0}}, q_abs_q};
            cnt_q    <= '0;
            state_q  <= SQ_Q;
          end else begin
            mplier_q <= mplier_q >> 1;
            mcand_q  <= mcand_q << 1;
            cnt_q    <= cnt_q + CW'(1);
          end
        end
        SQ_Q: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          mcand_q  <= mcand_q << 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            // Sum is at most 2^(2W-1), so no carry-out bit is needed.
            mag2_q  <= acc_d;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.rdy  = rdy_q;
  assign bus.mag2 = mag2_q;
endmodule
